// File: rtl/ysyx_25030093_axi_arbiter.sv
// ysyx_25030093_axi_arbiter: three-master (IFU read, LSU read, LSU write) to
// single-SRAM AXI-lite arbiter. One transaction owns the SRAM at a time; the
// owner's channels are forwarded combinationally, everything else reads 0.
// Optional feature macro: YSYX_25030093_ARB_RR_EN selects round-robin between
// IFU and LSU instead of fixed priority (LSU_WR > LSU_RD > IFU_RD).
module ysyx_25030093_axi_arbiter (
   input  logic        clk,
   input  logic        rst,
   // IFU read master
   input  logic [31:0] ifu_araddr,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   output logic [31:0] ifu_rdata,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   // LSU read master
   input  logic [31:0] lsu_araddr,
   input  logic        lsu_arvalid,
   output logic        lsu_arready,
   output logic [31:0] lsu_rdata,
   output logic        lsu_rvalid,
   input  logic        lsu_rready,
   // LSU write master
   input  logic [31:0] lsu_awaddr,
   input  logic        lsu_awvalid,
   output logic        lsu_awready,
   input  logic [31:0] lsu_wdata,
   input  logic [7:0]  lsu_wstrb,
   input  logic        lsu_wvalid,
   output logic        lsu_wready,
   output logic        lsu_bvalid,
   input  logic        lsu_bready,
   // SRAM slave
   output logic [31:0] sram_araddr,
   output logic        sram_arvalid,
   input  logic        sram_arready,
   input  logic [31:0] sram_rdata,
   input  logic        sram_rvalid,
   output logic        sram_rready,
   output logic [31:0] sram_awaddr,
   output logic        sram_awvalid,
   input  logic        sram_awready,
   output logic [31:0] sram_wdata,
   output logic [7:0]  sram_wstrb,
   output logic        sram_wvalid,
   input  logic        sram_wready,
   input  logic        sram_bvalid,
   output logic        sram_bready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;      // AR or AW address captured at handshake
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic        ar_done_q, ar_done_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        post_rst_q, post_rst_d; // first cycle after reset: all outputs 0
   logic        drain_q, drain_d;       // second cycle: swallow stale R/B
`ifdef YSYX_25030093_ARB_RR_EN
   logic        last_ifu_q, last_ifu_d; // 1 = IFU got the last grant
`endif

   logic        lsu_wr_req;
   logic        lsu_req;
   state_e      lsu_grant;
   state_e      grant;
   logic        out_en;

   assign out_en = ~rst & ~post_rst_q;

   // Pick the next owner from the requests visible this cycle.
   always_comb begin
      lsu_wr_req = lsu_awvalid | lsu_wvalid;
      lsu_req    = lsu_wr_req | lsu_arvalid;
      lsu_grant  = lsu_wr_req ? LSU_WR : LSU_RD;
      grant      = IDLE;
`ifdef YSYX_25030093_ARB_RR_EN
      if (lsu_req && ifu_arvalid) grant = last_ifu_q ? lsu_grant : IFU_RD;
      else if (lsu_req)           grant = lsu_grant;
      else if (ifu_arvalid)       grant = IFU_RD;
`else
      if (lsu_req)                grant = lsu_grant;
      else if (ifu_arvalid)       grant = IFU_RD;
`endif
   end

   // Forward only the owner's channels; done flags mask repeat handshakes.
   always_comb begin
      ifu_arready  = 1'b0;
      ifu_rdata    = '0;
      ifu_rvalid   = 1'b0;
      lsu_arready  = 1'b0;
      lsu_rdata    = '0;
      lsu_rvalid   = 1'b0;
      lsu_awready  = 1'b0;
      lsu_wready   = 1'b0;
      lsu_bvalid   = 1'b0;
      sram_araddr  = '0;
      sram_arvalid = 1'b0;
      sram_rready  = 1'b0;
      sram_awaddr  = '0;
      sram_awvalid = 1'b0;
      sram_wdata   = '0;
      sram_wstrb   = '0;
      sram_wvalid  = 1'b0;
      sram_bready  = 1'b0;
      if (out_en) begin
         case (state_q)
            IDLE: begin
               sram_rready = drain_q;
               sram_bready = drain_q;
            end
            IFU_RD: begin
               sram_araddr  = ar_done_q ? addr_q : ifu_araddr;
               sram_arvalid = ifu_arvalid & ~ar_done_q;
               ifu_arready  = sram_arready & ~ar_done_q;
               ifu_rvalid   = sram_rvalid & ar_done_q;
               sram_rready  = ifu_rready & ar_done_q;
               ifu_rdata    = sram_rdata;
            end
            LSU_RD: begin
               sram_araddr  = ar_done_q ? addr_q : lsu_araddr;
               sram_arvalid = lsu_arvalid & ~ar_done_q;
               lsu_arready  = sram_arready & ~ar_done_q;
               lsu_rvalid   = sram_rvalid & ar_done_q;
               sram_rready  = lsu_rready & ar_done_q;
               lsu_rdata    = sram_rdata;
            end
            LSU_WR: begin
               sram_awaddr  = aw_done_q ? addr_q : lsu_awaddr;
               sram_awvalid = lsu_awvalid & ~aw_done_q;
               lsu_awready  = sram_awready & ~aw_done_q;
               sram_wdata   = w_done_q ? wdata_q : lsu_wdata;
               sram_wstrb   = w_done_q ? wstrb_q : lsu_wstrb;
               sram_wvalid  = lsu_wvalid & ~w_done_q;
               lsu_wready   = sram_wready & ~w_done_q;
               lsu_bvalid   = sram_bvalid & aw_done_q & w_done_q;
               sram_bready  = lsu_bready & aw_done_q & w_done_q;
            end
            default: ;
         endcase
      end
   end

   // Next-state: grant from IDLE, track handshakes, release on R/B.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      ar_done_d  = ar_done_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      post_rst_d = 1'b0;
      drain_d    = post_rst_q;
`ifdef YSYX_25030093_ARB_RR_EN
      last_ifu_d = last_ifu_q;
`endif
      case (state_q)
         IDLE: begin
            if (!post_rst_q && !drain_q && grant != IDLE) begin
               state_d = grant;
`ifdef YSYX_25030093_ARB_RR_EN
               last_ifu_d = (grant == IFU_RD);
`endif
            end
         end
         IFU_RD, LSU_RD: begin
            if (sram_arvalid && sram_arready) begin
               ar_done_d = 1'b1;
               addr_d    = sram_araddr;
            end
            if (sram_rvalid && sram_rready) begin
               state_d   = IDLE;
               ar_done_d = 1'b0;
            end
         end
         LSU_WR: begin
            if (sram_awvalid && sram_awready) begin
               aw_done_d = 1'b1;
               addr_d    = lsu_awaddr;
            end
            if (sram_wvalid && sram_wready) begin
               w_done_d = 1'b1;
               wdata_d  = lsu_wdata;
               wstrb_d  = lsu_wstrb;
            end
            if (sram_bvalid && sram_bready) begin
               state_d   = IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         ar_done_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         post_rst_q <= 1'b1;
         drain_q    <= 1'b0;
`ifdef YSYX_25030093_ARB_RR_EN
         last_ifu_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         ar_done_q  <= ar_done_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         post_rst_q <= post_rst_d;
         drain_q    <= drain_d;
`ifdef YSYX_25030093_ARB_RR_EN
         last_ifu_q <= last_ifu_d;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_axi_arbiter.sv
// tb_ysyx_25030093_axi_arbiter: directed master transactions against a small
// SRAM model; expected SRAM-side and master-side beats are queued by the
// stimulus and popped by an independent monitor.
module tb_ysyx_25030093_axi_arbiter;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ifu_araddr = '0;
   logic        ifu_arvalid = 1'b0, ifu_rready = 1'b0;
   logic        ifu_arready, ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic [31:0] lsu_araddr = '0;
   logic        lsu_arvalid = 1'b0, lsu_rready = 1'b0;
   logic        lsu_arready, lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic [31:0] lsu_awaddr = '0, lsu_wdata = '0;
   logic [7:0]  lsu_wstrb = '0;
   logic        lsu_awvalid = 1'b0, lsu_wvalid = 1'b0, lsu_bready = 1'b0;
   logic        lsu_awready, lsu_wready, lsu_bvalid;
   logic [31:0] sram_araddr, sram_rdata, sram_awaddr, sram_wdata;
   logic [7:0]  sram_wstrb;
   logic        sram_arvalid, sram_arready, sram_rvalid, sram_rready;
   logic        sram_awvalid, sram_awready, sram_wvalid, sram_wready;
   logic        sram_bvalid, sram_bready;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int cyc_lsu_r = 0;
   int cyc_ifu_ar = 0;

   logic [31:0] q_ar[$], q_aw[$], q_ifu_r[$], q_lsu_r[$];
   logic [39:0] q_w[$];
   bit          q_b[$];

   ysyx_25030093_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
      .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .sram_araddr(sram_araddr), .sram_arvalid(sram_arvalid), .sram_arready(sram_arready),
      .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid), .sram_rready(sram_rready),
      .sram_awaddr(sram_awaddr), .sram_awvalid(sram_awvalid), .sram_awready(sram_awready),
      .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_wvalid(sram_wvalid),
      .sram_wready(sram_wready), .sram_bvalid(sram_bvalid), .sram_bready(sram_bready)
   );

   always #5 clk = ~clk;

   wire any_out = |{ifu_arready, ifu_rdata, ifu_rvalid, lsu_arready, lsu_rdata, lsu_rvalid,
                    lsu_awready, lsu_wready, lsu_bvalid, sram_araddr, sram_arvalid,
                    sram_rready, sram_awaddr, sram_awvalid, sram_wdata, sram_wstrb,
                    sram_wvalid, sram_bready};
   wire lsu_any = |{lsu_arready, lsu_rdata, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};

   // SRAM model: one read and one write outstanding, response a cycle later.
   // It ignores rst so a response in flight across a reset stays pending.
   logic        s_rvalid = 1'b0, s_bvalid = 1'b0, aw_got = 1'b0, w_got = 1'b0;
   logic [31:0] s_rdata = '0;
   wire         s_aw_hs = sram_awvalid & sram_awready;
   wire         s_w_hs  = sram_wvalid & sram_wready;
   assign sram_arready = ~s_rvalid;
   assign sram_rvalid  = s_rvalid;
   assign sram_rdata   = s_rdata;
   assign sram_awready = ~aw_got & ~s_bvalid;
   assign sram_wready  = ~w_got & ~s_bvalid;
   assign sram_bvalid  = s_bvalid;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      if (a == 32'h8000_1000) return 32'h1234_5678;
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (sram_arvalid && sram_arready) begin
         s_rvalid <= 1'b1;
         s_rdata  <= mem_rd(sram_araddr);
      end else if (s_rvalid && sram_rready) s_rvalid <= 1'b0;
      if (s_bvalid && sram_bready) s_bvalid <= 1'b0;
      else if ((aw_got | s_aw_hs) && (w_got | s_w_hs)) begin
         s_bvalid <= 1'b1;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
      end else begin
         if (s_aw_hs) aw_got <= 1'b1;
         if (s_w_hs)  w_got  <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [63:0] act);
      compared++;
      mismatched++;
      $display("FAIL %s: got unexpected beat %0h want none", nm, act);
   endtask

   // Monitor: pop and compare on every handshake the DUT presents.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (sram_arvalid && sram_arready) begin
            if (q_ar.size() == 0) unexpected("sram_ar", sram_araddr);
            else chk("sram_ar", sram_araddr, q_ar.pop_front());
         end
         if (ifu_arvalid && ifu_arready) cyc_ifu_ar = cyc;
         if (sram_awvalid && sram_awready) begin
            if (q_aw.size() == 0) unexpected("sram_aw", sram_awaddr);
            else chk("sram_aw", sram_awaddr, q_aw.pop_front());
         end
         if (sram_wvalid && sram_wready) begin
            if (q_w.size() == 0) unexpected("sram_w", {sram_wdata, sram_wstrb});
            else chk("sram_w", {sram_wdata, sram_wstrb}, q_w.pop_front());
         end
         if (ifu_rvalid && ifu_rready) begin
            if (q_ifu_r.size() == 0) unexpected("ifu_r", ifu_rdata);
            else chk("ifu_r", ifu_rdata, q_ifu_r.pop_front());
         end
         if (lsu_rvalid && lsu_rready) begin
            cyc_lsu_r = cyc;
            if (q_lsu_r.size() == 0) unexpected("lsu_r", lsu_rdata);
            else chk("lsu_r", lsu_rdata, q_lsu_r.pop_front());
         end
         if (lsu_bvalid && lsu_bready) begin
            if (q_b.size() == 0) unexpected("lsu_b", 64'd1);
            else chk("lsu_b", 64'd1, {63'd0, q_b.pop_front()});
         end
      end
   end

   // IFU read; with hold>0 rready stays low for hold cycles after rvalid while
   // a second AR is offered, which must not be accepted.
   task automatic ifu_read(input logic [31:0] a, input logic [31:0] exp, input int hold);
      int n;
      q_ifu_r.push_back(exp);
      ifu_araddr = a; ifu_arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ifu_arready && n < TMO);
      chk("ifu_ar_wait", ifu_arready, 1);
      @(posedge clk); #1; ifu_arvalid = 1'b0;
      if (hold > 0) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!ifu_rvalid && n < TMO);
         chk("ifu_rvalid_wait", ifu_rvalid, 1);
         ifu_araddr = a + 32'h100; ifu_arvalid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_sram_rvalid", sram_rvalid, 1);
            chk("hold_sram_rdata", sram_rdata, exp);
            chk("hold_other_arready", lsu_arready, 0);
            chk("hold_second_ar", {ifu_arready, sram_arvalid}, 0);
         end
         @(posedge clk); #1; ifu_arvalid = 1'b0;
      end
      ifu_rready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ifu_rvalid && n < TMO);
      chk("ifu_r_wait", ifu_rvalid, 1);
      @(posedge clk); #1; ifu_rready = 1'b0;
   endtask

   task automatic lsu_read(input logic [31:0] a, input logic [31:0] exp);
      int n;
      q_lsu_r.push_back(exp);
      lsu_araddr = a; lsu_arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!lsu_arready && n < TMO);
      chk("lsu_ar_wait", lsu_arready, 1);
      @(posedge clk); #1; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!lsu_rvalid && n < TMO);
      chk("lsu_r_wait", lsu_rvalid, 1);
      @(posedge clk); #1; lsu_rready = 1'b0;
   endtask

   // LSU write; W is presented w_lead cycles before AW.
   task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                            input int w_lead);
      int n;
      bit aw_ok, w_ok, aw_hs, w_hs;
      q_aw.push_back(a); q_w.push_back({d, s}); q_b.push_back(1'b1);
      aw_ok = 0; w_ok = 0; n = 0;
      lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s;
      lsu_wvalid = 1'b1; lsu_awvalid = (w_lead == 0);
      while (!(aw_ok && w_ok) && n < TMO) begin
         @(negedge clk);
         aw_hs = lsu_awvalid & lsu_awready;
         w_hs  = lsu_wvalid & lsu_wready;
         @(posedge clk); #1;
         n++;
         if (aw_hs) begin aw_ok = 1; lsu_awvalid = 1'b0; end
         if (w_hs)  begin w_ok = 1;  lsu_wvalid = 1'b0; end
         if (!aw_ok && n >= w_lead) lsu_awvalid = 1'b1;
      end
      chk("lsu_aw_w_wait", {aw_ok, w_ok}, 2'b11);
      lsu_bready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!lsu_bvalid && n < TMO);
      chk("lsu_b_wait", lsu_bvalid, 1);
      @(posedge clk); #1; lsu_bready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk); chk("reset_outs_zero", any_out, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk); chk("post_reset_outs_zero", any_out, 0);
      repeat (2) @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit quiet;
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk); chk("reset_outs_zero", any_out, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk); chk("post_reset_outs_zero", any_out, 0);
      repeat (2) @(posedge clk); #1;

      // IFU alone; LSU side stays silent, arbiter back to IDLE afterwards
      q_ar.push_back(32'h8000_0000);
      quiet = 1'b0;
      fork
         ifu_read(32'h8000_0000, 32'h0000_0413, 0);
         for (int i = 0; i < 6; i++) begin @(negedge clk); quiet |= lsu_any; end
      join
      chk("ifu_only_lsu_quiet", quiet, 0);
      @(negedge clk); chk("idle_after_ifu", any_out, 0);
      @(posedge clk); #1;

      // simultaneous reads: LSU first, IFU one IDLE cycle after LSU's R
      q_ar.push_back(32'h8000_1000);
      q_ar.push_back(32'h8000_0000);
      fork
         ifu_read(32'h8000_0000, 32'h0000_0413, 0);
         lsu_read(32'h8000_1000, 32'h1234_5678);
      join
      chk("prio_gap", cyc_ifu_ar - cyc_lsu_r, 2);

      // writes: W two cycles ahead of AW, then AW and W together
      lsu_write(32'h8000_2004, 32'hDEAD_BEEF, 8'h0F, 2);
      @(negedge clk); chk("idle_after_write", any_out, 0);
      @(posedge clk); #1;
      lsu_write(32'h8000_2008, 32'h0102_0304, 8'hFF, 0);

      // owner stalls R for 10 cycles while the LSU waits
      q_ar.push_back(32'h8000_0000);
      q_ar.push_back(32'h8000_1000);
      fork
         ifu_read(32'h8000_0000, 32'h0000_0413, 10);
         begin repeat (3) @(posedge clk); #1; lsu_read(32'h8000_1000, 32'h1234_5678); end
      join

      // reset during LSU_RD with the SRAM response pending
      @(posedge clk); #1;
      q_ar.push_back(32'h8000_1000);
      lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1; lsu_rready = 1'b0;
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!lsu_arready && n < TMO);
         chk("rst_lsu_ar_wait", lsu_arready, 1);
         @(posedge clk); #1; lsu_arvalid = 1'b0;
         n = 0;
         do begin @(negedge clk); n++; end while (!lsu_rvalid && n < TMO);
         chk("rst_lsu_rvalid_pending", lsu_rvalid, 1);
      end
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk); chk("mid_reset_outs_zero", any_out, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk); chk("mid_post_reset_outs_zero", any_out, 0);
      @(negedge clk); chk("stale_r_blocked", |{ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata}, 0);
      @(posedge clk); #1;
      q_ar.push_back(32'h8000_0000);
      ifu_read(32'h8000_0000, 32'h0000_0413, 0);

      // both masters streaming three reads each from a fresh reset
      do_reset();
`ifdef YSYX_25030093_ARB_RR_EN
      q_ar.push_back(32'h8000_1000); q_ar.push_back(32'h8000_0000);
      q_ar.push_back(32'h8000_1004); q_ar.push_back(32'h8000_0004);
      q_ar.push_back(32'h8000_1008); q_ar.push_back(32'h8000_0008);
`else
      q_ar.push_back(32'h8000_1000); q_ar.push_back(32'h8000_1004);
      q_ar.push_back(32'h8000_1008); q_ar.push_back(32'h8000_0000);
      q_ar.push_back(32'h8000_0004); q_ar.push_back(32'h8000_0008);
`endif
      fork
         begin
            ifu_read(32'h8000_0000, 32'h0000_0413, 0);
            ifu_read(32'h8000_0004, 32'h25A5_0004, 0);
            ifu_read(32'h8000_0008, 32'h25A5_0008, 0);
         end
         begin
            lsu_read(32'h8000_1000, 32'h1234_5678);
            lsu_read(32'h8000_1004, 32'h25A5_1004);
            lsu_read(32'h8000_1008, 32'h25A5_1008);
         end
      join

      repeat (3) @(posedge clk);
      chk("q_ar_drained", q_ar.size(), 0);
      chk("q_aw_drained", q_aw.size(), 0);
      chk("q_w_drained", q_w.size(), 0);
      chk("q_ifu_r_drained", q_ifu_r.size(), 0);
      chk("q_lsu_r_drained", q_lsu_r.size(), 0);
      chk("q_b_drained", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
